// File: rtl/pipe_scr_pkg.sv
// Shared constants and the per-byte scramble step for the PIPE descrambler.
// Holds the K-codes, LFSR seed, tap mask and a (lfsr, byte, k) step function.
package pipe_scr_pkg;

    localparam logic [7:0]  COM_SYM   = 8'hBC;
    localparam logic [7:0]  SKP_SYM   = 8'h1C;
    localparam logic [15:0] LFSR_SEED = 16'hFFFF;
    localparam logic [15:0] LFSR_TAPS = 16'h0039;

    typedef struct packed {
        logic [7:0]  data;
        logic [15:0] lfsr;
    } scr_step_t;

    // Data bit 0 meets the key first; taps are folded in Galois style.
    function automatic scr_step_t scr_step(
        input logic [15:0] lfsrIn,
        input logic [7:0]  dataIn,
        input logic        k
    );
        scr_step_t r;
        logic [15:0] s;
        logic        kb;
        r.data = dataIn;
        r.lfsr = lfsrIn;
        s      = lfsrIn;
        kb     = 1'b0;
        if (k && dataIn == COM_SYM) begin
            r.lfsr = LFSR_SEED;
        end else if (!(k && dataIn == SKP_SYM)) begin
            for (int i = 0; i < 8; i++) begin
                kb = s[15];
                if (!k) r.data[i] = dataIn[i] ^ kb;
                s = {s[14:0], 1'b0} ^ (kb ? LFSR_TAPS : 16'h0000);
            end
            r.lfsr = s;
        end
        return r;
    endfunction

endpackage

// File: rtl/scr_byte_lane.sv
// Combinational single-byte (de)scrambler lane; lanes chain via lfsrIn/lfsrOut.
// Ports: active, turnOff, reloadVal, lfsrIn, dataIn, kIn -> dataOut, kOut, lfsrOut.
module scr_byte_lane
    import pipe_scr_pkg::*;
(
    input  logic        active,
    input  logic        turnOff,
    input  logic [15:0] reloadVal,
    input  logic [15:0] lfsrIn,
    input  logic [7:0]  dataIn,
    input  logic        kIn,
    output logic [7:0]  dataOut,
    output logic        kOut,
    output logic [15:0] lfsrOut
);

    scr_step_t step;
    logic      isCom;

    always_comb begin
        step    = scr_step(lfsrIn, dataIn, kIn);
        isCom   = kIn && (dataIn == COM_SYM);
        dataOut = 8'h00;
        kOut    = 1'b0;
        lfsrOut = lfsrIn;
        if (active) begin
            kOut = kIn;
            if (isCom) begin
                // COM reloads even in bypass.
                dataOut = dataIn;
                lfsrOut = reloadVal;
            end else if (turnOff) begin
                dataOut = dataIn;
            end else begin
                dataOut = step.data;
                lfsrOut = step.lfsr;
            end
        end
    end

endmodule

// File: rtl/pipe_descrambler.sv
// PCIe Gen1/2 per-lane PIPE RX descrambler (also usable as scrambler), 1-clock latency.
// Ports: clk, reset, turnOff, PIPEDataValid, PIPEWIDTH, PIPESyncHeader, seedValue,
//   PIPEData, PIPEDataK -> descramblerDataValid, descramblerData, descramblerDataK,
//   descramblerSyncHeader. Macro DESCRAMBLER_SEED_EN enables seedValue[15:0] reload.
module pipe_descrambler
    import pipe_scr_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        turnOff,
    input  logic        PIPEDataValid,
    input  logic [5:0]  PIPEWIDTH,
    input  logic [1:0]  PIPESyncHeader,
    input  logic [23:0] seedValue,
    input  logic [31:0] PIPEData,
    input  logic [3:0]  PIPEDataK,
    output logic        descramblerDataValid,
    output logic [31:0] descramblerData,
    output logic [3:0]  descramblerDataK,
    output logic [1:0]  descramblerSyncHeader
);

    logic [15:0]      lfsr;
    logic [15:0]      reloadVal;
    logic [3:0]       laneActive;
    logic [4:0][15:0] lfsrChain;
    logic [31:0]      dataNext;
    logic [3:0]       kNext;

`ifdef DESCRAMBLER_SEED_EN
    logic [7:0] unusedSeedHi;
    assign unusedSeedHi = seedValue[23:16];
    assign reloadVal = (seedValue[15:0] != 16'h0000) ? seedValue[15:0] : LFSR_SEED;
`else
    logic [23:0] unusedSeed;
    assign unusedSeed = seedValue;
    assign reloadVal  = LFSR_SEED;
`endif

    // Illegal widths fall back to the full 4-lane word.
    always_comb begin
        laneActive = 4'b1111;
        unique case (1'b1)
            (PIPEWIDTH == 6'd8):  laneActive = 4'b0001;
            (PIPEWIDTH == 6'd16): laneActive = 4'b0011;
            default:              laneActive = 4'b1111;
        endcase
    end

    assign lfsrChain[0] = lfsr;

    for (genvar i = 0; i < 4; i++) begin : gLane
        scr_byte_lane uLane (
            .active    (laneActive[i]),
            .turnOff   (turnOff),
            .reloadVal (reloadVal),
            .lfsrIn    (lfsrChain[i]),
            .dataIn    (PIPEData[8*i +: 8]),
            .kIn       (PIPEDataK[i]),
            .dataOut   (dataNext[8*i +: 8]),
            .kOut      (kNext[i]),
            .lfsrOut   (lfsrChain[i+1])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr                  <= reloadVal;
            descramblerDataValid  <= 1'b0;
            descramblerData       <= 32'h0;
            descramblerDataK      <= 4'h0;
            descramblerSyncHeader <= 2'b00;
        end else begin
            descramblerDataValid <= PIPEDataValid;
            if (PIPEDataValid) begin
                lfsr                  <= lfsrChain[4];
                descramblerData       <= dataNext;
                descramblerDataK      <= kNext;
                descramblerSyncHeader <= PIPESyncHeader;
            end
        end
    end

endmodule

// File: tb/tb_pipe_descrambler.sv
// Self-checking bench for pipe_descrambler: vector table, corner sequences, random vs model.
// A second instance descrambles the first instance's output for the round-trip check.
module tb_pipe_descrambler;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        turnOff = 1'b0;
    logic        PIPEDataValid = 1'b0;
    logic [5:0]  PIPEWIDTH = 6'd32;
    logic [1:0]  PIPESyncHeader = 2'b00;
    logic [23:0] seedValue = 24'h0;
    logic [31:0] PIPEData = 32'h0;
    logic [3:0]  PIPEDataK = 4'h0;

    logic        scrValid;
    logic [31:0] scrData;
    logic [3:0]  scrK;
    logic [1:0]  scrSync;
    logic        dscValid;
    logic [31:0] dscData;
    logic [3:0]  dscK;
    logic [1:0]  dscSync;

    int nVec = 0;
    int nFail = 0;

    always #5 clk = ~clk;

    pipe_descrambler dut (
        .clk                   (clk),
        .reset                 (reset),
        .turnOff               (turnOff),
        .PIPEDataValid         (PIPEDataValid),
        .PIPEWIDTH             (PIPEWIDTH),
        .PIPESyncHeader        (PIPESyncHeader),
        .seedValue             (seedValue),
        .PIPEData              (PIPEData),
        .PIPEDataK             (PIPEDataK),
        .descramblerDataValid  (scrValid),
        .descramblerData       (scrData),
        .descramblerDataK      (scrK),
        .descramblerSyncHeader (scrSync)
    );

    pipe_descrambler dutChain (
        .clk                   (clk),
        .reset                 (reset),
        .turnOff               (turnOff),
        .PIPEDataValid         (scrValid),
        .PIPEWIDTH             (PIPEWIDTH),
        .PIPESyncHeader        (scrSync),
        .seedValue             (seedValue),
        .PIPEData              (scrData),
        .PIPEDataK             (scrK),
        .descramblerDataValid  (dscValid),
        .descramblerData       (dscData),
        .descramblerDataK      (dscK),
        .descramblerSyncHeader (dscSync)
    );

    typedef struct {
        logic        rst;
        logic        valid;
        logic [5:0]  width;
        logic        toff;
        logic [3:0]  k;
        logic [31:0] data;
        logic [1:0]  sync;
        logic        expValid;
        logic [3:0]  expK;
        logic [31:0] expData;
        logic [1:0]  expSync;
    } vec_t;

    vec_t vecs[16];

    function automatic vec_t mk(
        input logic rst, input logic valid, input logic [5:0] width,
        input logic toff, input logic [3:0] k, input logic [31:0] data,
        input logic [1:0] sync, input logic ev, input logic [3:0] ek,
        input logic [31:0] ed, input logic [1:0] es
    );
        vec_t v;
        v.rst = rst; v.valid = valid; v.width = width; v.toff = toff;
        v.k = k; v.data = data; v.sync = sync; v.expValid = ev;
        v.expK = ek; v.expData = ed; v.expSync = es;
        return v;
    endfunction

    task automatic check(input string name, input logic [38:0] act, input logic [38:0] exp);
        nVec++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [38:0] dutOut();
        return {scrValid, scrK, scrSync, scrData};
    endfunction

    task automatic doReset();
        @(negedge clk);
        reset = 1'b1;
        PIPEDataValid = 1'b0;
        #1;
        check("reset_state", dutOut(), 39'h0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Reference model: key stream generated bit by bit from the polynomial rule.
    logic [15:0] mS;
    logic        mValid;
    logic [31:0] mData;
    logic [3:0]  mK;
    logic [1:0]  mSync;

    function automatic logic [23:0] keyStep(input logic [15:0] s);
        logic [7:0]  key;
        logic [15:0] t;
        t = s;
        key = 8'h0;
        for (int i = 0; i < 8; i++) begin
            key[i] = t[15];
            t = {t[14:0], 1'b0} ^ (key[i] ? 16'h0039 : 16'h0000);
        end
        return {key, t};
    endfunction

    function automatic logic [15:0] reloadOf(input logic [23:0] sv);
`ifdef DESCRAMBLER_SEED_EN
        return (sv[15:0] != 16'h0) ? sv[15:0] : 16'hFFFF;
`else
        return 16'hFFFF + 16'h0 * sv[15:0];
`endif
    endfunction

    task automatic modelApply();
        int nl;
        logic [7:0]  b;
        logic [23:0] ks;
        mValid = PIPEDataValid;
        if (!PIPEDataValid) return;
        nl = (PIPEWIDTH == 6'd8) ? 1 : (PIPEWIDTH == 6'd16) ? 2 : 4;
        mSync = PIPESyncHeader;
        for (int i = 0; i < 4; i++) begin
            b = PIPEData[8*i +: 8];
            if (i >= nl) begin
                mData[8*i +: 8] = 8'h00;
                mK[i] = 1'b0;
            end else begin
                mK[i] = PIPEDataK[i];
                mData[8*i +: 8] = b;
                ks = keyStep(mS);
                if (PIPEDataK[i] && b == 8'hBC) mS = reloadOf(seedValue);
                else if (turnOff) mS = mS;
                else if (PIPEDataK[i] && b == 8'h1C) mS = mS;
                else if (PIPEDataK[i]) mS = ks[15:0];
                else begin
                    mData[8*i +: 8] = b ^ ks[23:16];
                    mS = ks[15:0];
                end
            end
        end
    endtask

    initial begin
        vecs[0]  = mk(1, 1, 32, 1, 4'b1010, 32'hAFAFAFAF, 2'b01, 1, 4'b1010, 32'hAFAFAFAF, 2'b01);
        vecs[1]  = mk(0, 1, 32, 0, 4'b0001, 32'h000000BC, 2'b10, 1, 4'b0001, 32'hC017FFBC, 2'b10);
        vecs[2]  = mk(0, 1, 32, 0, 4'b0000, 32'h00000000, 2'b11, 1, 4'b0000, 32'h02E7B214, 2'b11);
        vecs[3]  = mk(1, 1, 32, 0, 4'b0010, 32'hAFAFBCAF, 2'b00, 1, 4'b0010, 32'hB850BC50, 2'b00);
        vecs[4]  = mk(0, 1, 32, 0, 4'b0100, 32'hAF1CAFAF, 2'b01, 1, 4'b0100, 32'h1D1CBB6F, 2'b01);
        vecs[5]  = mk(1, 1,  8, 0, 4'b0001, 32'h000000BC, 2'b00, 1, 4'b0001, 32'h000000BC, 2'b00);
        vecs[6]  = mk(0, 1,  8, 0, 4'b1110, 32'h12345600, 2'b01, 1, 4'b0000, 32'h000000FF, 2'b01);
        vecs[7]  = mk(0, 1,  8, 0, 4'b0000, 32'hABCDEF00, 2'b11, 1, 4'b0000, 32'h00000017, 2'b11);
        vecs[8]  = mk(1, 1, 16, 0, 4'b0001, 32'h000000BC, 2'b01, 1, 4'b0001, 32'h0000FFBC, 2'b01);
        vecs[9]  = mk(0, 1, 16, 0, 4'b0000, 32'hAAAA0000, 2'b10, 1, 4'b0000, 32'h0000C017, 2'b10);
        vecs[10] = mk(0, 0, 16, 0, 4'b1111, 32'hFFFFFFFF, 2'b11, 0, 4'b0000, 32'h0000C017, 2'b10);
        vecs[11] = mk(0, 1, 16, 0, 4'b0000, 32'h00000000, 2'b01, 1, 4'b0000, 32'h0000B214, 2'b01);
        vecs[12] = mk(1, 1, 20, 0, 4'b0000, 32'h00000000, 2'b10, 1, 4'b0000, 32'h14C017FF, 2'b10);
        vecs[13] = mk(0, 1,  0, 1, 4'b0000, 32'h12345678, 2'b11, 1, 4'b0000, 32'h12345678, 2'b11);
        vecs[14] = mk(0, 1, 32, 1, 4'b0100, 32'h00BC0000, 2'b00, 1, 4'b0100, 32'h00BC0000, 2'b00);
        vecs[15] = mk(0, 1, 32, 0, 4'b0000, 32'h00000000, 2'b01, 1, 4'b0000, 32'h14C017FF, 2'b01);

        reset = 1'b1;
        #1;
        check("power_on_reset", dutOut(), 39'h0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            if (vecs[i].rst) doReset();
            PIPEDataValid  = vecs[i].valid;
            PIPEWIDTH      = vecs[i].width;
            turnOff        = vecs[i].toff;
            PIPEDataK      = vecs[i].k;
            PIPEData       = vecs[i].data;
            PIPESyncHeader = vecs[i].sync;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), dutOut(),
                  {vecs[i].expValid, vecs[i].expK, vecs[i].expSync, vecs[i].expData});
        end

        // Scrambler followed by descrambler restores the original words.
        doReset();
        PIPEWIDTH = 6'd32; turnOff = 1'b0; PIPEDataK = 4'h0; PIPESyncHeader = 2'b00;
        PIPEDataValid = 1'b1; PIPEData = 32'hAFAFAFAF;
        @(posedge clk); #1;
        check("chain_scrambled", dutOut(), {1'b1, 4'h0, 2'b00, 32'hBB6FB850});
        PIPEData = 32'hBFBFBFBF;
        @(posedge clk); #1;
        check("chain_word0", {dscValid, dscK, dscSync, dscData}, {1'b1, 4'h0, 2'b00, 32'hAFAFAFAF});
        PIPEDataValid = 1'b0;
        @(posedge clk); #1;
        check("chain_word1", {dscValid, dscK, dscSync, dscData}, {1'b1, 4'h0, 2'b00, 32'hBFBFBFBF});

        // Reset asserted between clock edges clears outputs at once.
        PIPEDataValid = 1'b1; PIPEData = 32'h5A5A5A5A; PIPEDataK = 4'hF;
        @(posedge clk); #1;
        check("pre_midreset", dutOut(), {1'b1, 4'hF, 2'b00, 32'h5A5A5A5A});
        #2 reset = 1'b1;
        #1;
        check("mid_word_reset", dutOut(), 39'h0);
        @(negedge clk);
        reset = 1'b0;

        // Randomized stimulus against the model.
        seedValue = 24'h0;
        doReset();
        mS = reloadOf(seedValue);
        mValid = 1'b0; mData = 32'h0; mK = 4'h0; mSync = 2'b00;
        for (int c = 0; c < 1500; c++) begin
            PIPEDataValid = ($urandom_range(0, 9) < 8);
            turnOff       = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 3))
                0:       PIPEWIDTH = 6'd8;
                1:       PIPEWIDTH = 6'd16;
                2:       PIPEWIDTH = 6'd32;
                default: PIPEWIDTH = 6'($urandom_range(0, 63));
            endcase
            PIPESyncHeader = 2'($urandom_range(0, 3));
            seedValue      = 24'($urandom);
            PIPEData       = $urandom;
            for (int i = 0; i < 4; i++) begin
                PIPEDataK[i] = ($urandom_range(0, 3) == 0);
                if (PIPEDataK[i]) begin
                    case ($urandom_range(0, 2))
                        0:       PIPEData[8*i +: 8] = 8'hBC;
                        1:       PIPEData[8*i +: 8] = 8'h1C;
                        default: PIPEData[8*i +: 8] = 8'($urandom);
                    endcase
                end
            end
            modelApply();
            @(posedge clk); #1;
            check($sformatf("rand%0d", c), dutOut(), {mValid, mK, mSync, mData});
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end

endmodule
